// File: rtl/spi_dma.sv
// rtl/spi_dma.sv - byte-stream DMA sequencer between a byte memory port and the SPI byte shifter.
// Optional SD data CRC16 on every byte moved, enabled by SPI_DMA_CRC16_EN.
module spi_dma #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [12:0]       byte_count,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        sh_mode,
  output logic [12:0]       sh_new_rx_length,
  output logic              sh_set_rx_length,
  output logic              sh_wr_req,
  output logic [7:0]        sh_data_in,
  input  logic              sh_in_full,
  output logic              sh_rd_req,
  input  logic [7:0]        sh_data_out,
  input  logic              sh_out_full,
  input  logic              sh_busy,
  output logic [15:0]       crc_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_TX_FETCH = 3'd2;
  localparam logic [2:0] S_TX_PUSH  = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_RX_WAIT  = 3'd5;
  localparam logic [2:0] S_RX_STORE = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]        state;
  logic              dir_q;
  logic [ADDR_W-1:0] addr;
  logic [12:0]       remaining;
  logic [7:0]        data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dir_q     <= 1'b0;
      addr      <= '0;
      remaining <= 13'd0;
      data_q    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dir_q     <= dir;
            addr      <= base_addr;
            remaining <= byte_count;
            state     <= (byte_count == 13'd0) ? S_DONE : S_SETUP;
          end
        end
        S_SETUP: state <= dir_q ? S_RX_WAIT : S_TX_FETCH;
        S_TX_FETCH: begin
          if (mem_ack) begin
            data_q <= mem_rdata;
            addr   <= addr + 1'b1;
            state  <= S_TX_PUSH;
          end
        end
        S_TX_PUSH: begin
          // Leaving this state right after the push keeps sh_wr_req to single-cycle pulses.
          if (!sh_in_full) begin
            remaining <= remaining - 13'd1;
            state     <= (remaining == 13'd1) ? S_DRAIN : S_TX_FETCH;
          end
        end
        S_DRAIN: begin
          if (!sh_in_full && !sh_busy) state <= S_DONE;
        end
        S_RX_WAIT: begin
          if (sh_out_full) begin
            data_q <= sh_data_out;
            state  <= S_RX_STORE;
          end
        end
        S_RX_STORE: begin
          if (mem_ack) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 13'd1;
            state     <= (remaining == 13'd1) ? S_DONE : S_RX_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy             = (state != S_IDLE) && (state != S_DONE);
  assign done             = (state == S_DONE);
  assign mem_req          = (state == S_TX_FETCH) || (state == S_RX_STORE);
  assign mem_we           = (state == S_RX_STORE);
  assign mem_addr         = mem_req ? addr : '0;
  assign mem_wdata        = mem_we ? data_q : 8'd0;
  assign sh_set_rx_length = (state == S_SETUP) && dir_q;
  assign sh_new_rx_length = sh_set_rx_length ? remaining : 13'd0;
  assign sh_wr_req        = (state == S_TX_PUSH) && !sh_in_full;
  assign sh_data_in       = data_q;
  assign sh_rd_req        = (state == S_RX_WAIT) && sh_out_full;

  always_comb begin
    sh_mode = 2'd0;
    if ((state == S_TX_FETCH) || (state == S_TX_PUSH) || (state == S_DRAIN))
      sh_mode = 2'd2;
    else if ((state == S_RX_WAIT) || (state == S_RX_STORE))
      sh_mode = 2'd1;
  end

`ifdef SPI_DMA_CRC16_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      crc_q <= 16'h0000;
    else if ((state == S_IDLE) && start)
      crc_q <= 16'h0000;
    else if (sh_wr_req)
      crc_q <= crc16_byte(crc_q, data_q);
    else if (sh_rd_req)
      crc_q <= crc16_byte(crc_q, sh_data_out);
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 16'h0000;
`endif

endmodule

// File: tb/tb_spi_dma.sv
// tb/tb_spi_dma.sv - randomized bench for spi_dma with memory/shifter models and a transfer-level reference.
`define CHK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_spi_dma;
  logic        clk = 1'b0;
  logic        reset, start, dir;
  logic [15:0] base_addr;
  logic [12:0] byte_count;
  logic        busy, done, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [1:0]  sh_mode;
  logic [12:0] sh_new_rx_length;
  logic        sh_set_rx_length, sh_wr_req, sh_rd_req;
  logic [7:0]  sh_data_in, sh_data_out;
  logic        sh_in_full, sh_out_full, sh_busy;
  logic [15:0] crc_out;

  int total = 0;
  int bad = 0;

  spi_dma #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .base_addr(base_addr),
    .byte_count(byte_count), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .sh_mode(sh_mode), .sh_new_rx_length(sh_new_rx_length),
    .sh_set_rx_length(sh_set_rx_length), .sh_wr_req(sh_wr_req), .sh_data_in(sh_data_in),
    .sh_in_full(sh_in_full), .sh_rd_req(sh_rd_req), .sh_data_out(sh_data_out),
    .sh_out_full(sh_out_full), .sh_busy(sh_busy), .crc_out(crc_out)
  );

  always #5 clk = ~clk;

  // Bench-owned configuration and source data (written only by the stimulus).
  logic [7:0] tx_src [0:65535];
  logic [7:0] rx_src [0:4095];
  int rx_wr = 0;
  int mem_min = 0, mem_max = 2, drain_len = 4, rx_gap = 1;

  // Memory responder: ack after a random number of request cycles.
  int mem_cnt, mem_dly;
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (reset) begin
      mem_cnt <= 0;
      mem_dly <= 0;
    end else if (mem_req && !mem_ack) begin
      if (mem_cnt >= mem_dly) begin
        mem_ack <= 1'b1;
        if (!mem_we) mem_rdata <= tx_src[mem_addr];
        mem_cnt <= 0;
        mem_dly <= $urandom_range(mem_max, mem_min);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // Shifter model: holding register feeding a shift stage that takes drain_len cycles.
  logic in_full;
  int   sc;
  assign sh_in_full = in_full;
  assign sh_busy    = in_full || (sc != 0);
  always @(posedge clk) begin
    if (reset) begin
      in_full <= 1'b0;
      sc      <= 0;
    end else begin
      if (sh_wr_req) in_full <= 1'b1;
      else if (in_full && sc == 0) begin
        in_full <= 1'b0;
        sc      <= drain_len;
      end
      if (sc != 0) sc <= sc - 1;
    end
  end

  logic       out_full;
  logic [7:0] dout;
  int         gap, rx_rd = 0;
  assign sh_out_full = out_full;
  assign sh_data_out = dout;
  always @(posedge clk) begin
    if (reset) begin
      out_full <= 1'b0;
      gap      <= 0;
    end else if (sh_rd_req) begin
      out_full <= 1'b0;
      gap      <= rx_gap;
    end else if (!out_full && gap != 0) begin
      gap <= gap - 1;
    end else if (!out_full && rx_rd < rx_wr) begin
      out_full <= 1'b1;
      dout     <= rx_src[rx_rd];
      rx_rd    <= rx_rd + 1;
    end
  end

  // Event monitor.
  int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, set_cnt = 0, req_cyc = 0, viol = 0;
  logic [12:0] last_len;
  logic        prev_wr = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, prev_we;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wd;
  logic [7:0]  pushed [$];
  logic [15:0] wl_addr [$];
  logic [7:0]  wl_data [$];
  always @(posedge clk) begin
    prev_wr   <= sh_wr_req && !reset;
    prev_req  <= mem_req && !reset;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
    prev_we   <= mem_we;
    prev_wd   <= mem_wdata;
    if (!reset) begin
      if (done) done_cnt <= done_cnt + 1;
      if (mem_req) req_cyc <= req_cyc + 1;
      if (sh_rd_req) rd_cnt <= rd_cnt + 1;
      if (sh_set_rx_length) begin
        set_cnt  <= set_cnt + 1;
        last_len <= sh_new_rx_length;
      end
      if (sh_wr_req) begin
        wr_cnt <= wr_cnt + 1;
        pushed.push_back(sh_data_in);
      end
      if (mem_req && mem_ack && mem_we) begin
        wl_addr.push_back(mem_addr);
        wl_data.push_back(mem_wdata);
      end
      if ((sh_wr_req && (prev_wr || sh_in_full)) || (done && sh_busy) ||
          (prev_req && !prev_ack && (!mem_req || mem_addr != prev_addr ||
           mem_we != prev_we || mem_wdata != prev_wd)))
        viol <= viol + 1;
    end
  end

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) begin
      logic fb = r[15] ^ b[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_expect(input logic [15:0] model);
`ifdef SPI_DMA_CRC16_EN
    return model;
`else
    return model & 16'h0000;
`endif
  endfunction

  task automatic pulse_start(input logic d, input logic [15:0] b, input int n);
    dir = d; base_addr = b; byte_count = n[12:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int k = 0;
    while (done_cnt == d0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    `CHK({tag, "_timeout"}, (done_cnt != d0), 1'b1)
    repeat (3) @(negedge clk);
  endtask

  task automatic run_tx(input logic [15:0] base, input int n, input string tag);
    int p0 = pushed.size(), d0 = done_cnt, v0 = viol, errs = 0;
    logic [15:0] crc = 16'h0000;
    logic [15:0] a;
    pulse_start(1'b0, base, n);
    wait_done(d0, tag);
    `CHK({tag, "_done_once"}, done_cnt - d0, 1)
    `CHK({tag, "_push_count"}, pushed.size() - p0, n)
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      crc = crc_ref(crc, tx_src[a]);
      if (p0 + i >= pushed.size() || pushed[p0 + i] !== tx_src[a]) errs++;
    end
    `CHK({tag, "_push_data_errs"}, errs, 0)
    `CHK({tag, "_idle_mode_busy"}, {sh_mode, busy}, 3'b000)
    `CHK({tag, "_protocol"}, viol - v0, 0)
    `CHK({tag, "_crc"}, crc_out, crc_expect(crc))
  endtask

  task automatic run_rx(input logic [15:0] base, input int n, input string tag);
    int w0 = wl_addr.size(), d0 = done_cnt, v0 = viol, r0 = rd_cnt, s0 = set_cnt, q0 = rx_wr;
    int errs = 0;
    logic [15:0] crc = 16'h0000;
    rx_wr = q0 + n;
    pulse_start(1'b1, base, n);
    wait_done(d0, tag);
    `CHK({tag, "_done_once"}, done_cnt - d0, 1)
    `CHK({tag, "_set_len_once"}, set_cnt - s0, 1)
    `CHK({tag, "_set_len_value"}, last_len, n[12:0])
    `CHK({tag, "_rd_req_count"}, rd_cnt - r0, n)
    `CHK({tag, "_write_count"}, wl_addr.size() - w0, n)
    for (int i = 0; i < n; i++) begin
      crc = crc_ref(crc, rx_src[q0 + i]);
      if (w0 + i >= wl_addr.size() || wl_addr[w0 + i] !== base + 16'(i) ||
          wl_data[w0 + i] !== rx_src[q0 + i]) errs++;
    end
    `CHK({tag, "_write_errs"}, errs, 0)
    `CHK({tag, "_protocol"}, viol - v0, 0)
    `CHK({tag, "_crc"}, crc_out, crc_expect(crc))
  endtask

  initial begin
    int d0, w0, r0, s0, q0, p0, k;
    reset = 1'b1; start = 1'b0; dir = 1'b0; base_addr = 16'h0; byte_count = 13'd0;
    repeat (2) @(negedge clk);
    `CHK("reset_outputs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata, sh_mode,
         sh_new_rx_length, sh_set_rx_length, sh_wr_req, sh_data_in, sh_rd_req, crc_out}, 70'd0)
    reset = 1'b0;
    @(negedge clk);

    tx_src[16'h0100] = 8'hA5; tx_src[16'h0101] = 8'h3C; tx_src[16'h0102] = 8'h0F;
    drain_len = 20; mem_min = 0; mem_max = 2;
    run_tx(16'h0100, 3, "tx_basic");

    q0 = rx_wr;
    for (int i = 0; i < 4; i++) rx_src[q0 + i] = 8'(8'h11 * (i + 1));
    rx_gap = 1; drain_len = 4;
    run_rx(16'h0200, 4, "rx_basic");

    d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt; s0 = set_cnt; k = req_cyc;
    pulse_start(1'b1, 16'h1234, 0);
    repeat (2) @(negedge clk);
    `CHK("zero_done", done_cnt - d0, 1)
    `CHK("zero_no_activity", (wr_cnt - w0) + (rd_cnt - r0) + (set_cnt - s0) + (req_cyc - k), 0)

    mem_min = 15; mem_max = 15; rx_gap = 0;
    q0 = rx_wr;
    for (int i = 0; i < 6; i++) rx_src[q0 + i] = 8'($urandom);
    run_rx(16'h0400, 6, "rx_backpressure");
    mem_min = 0; mem_max = 3;
    q0 = rx_wr;
    for (int i = 0; i < 2; i++) rx_src[q0 + i] = 8'($urandom);
    run_rx(16'hFFFF, 2, "rx_wrap");

    for (int t = 0; t < 8; t++) begin
      logic [15:0] b = 16'($urandom);
      int n = $urandom_range(12, 1);
      mem_max = $urandom_range(4, 0); drain_len = $urandom_range(8, 1); rx_gap = $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 0) begin
        for (int i = 0; i < n; i++) tx_src[b + 16'(i)] = 8'($urandom);
        run_tx(b, n, "tx_rand");
      end else begin
        q0 = rx_wr;
        for (int i = 0; i < n; i++) rx_src[q0 + i] = 8'($urandom);
        run_rx(b, n, "rx_rand");
      end
    end

    for (int i = 0; i < 5; i++) tx_src[16'h0300 + 16'(i)] = 8'($urandom);
    drain_len = 6; mem_max = 1;
    d0 = done_cnt; p0 = pushed.size(); k = 0;
    pulse_start(1'b0, 16'h0300, 5);
    while (pushed.size() - p0 < 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    `CHK("rst_mid_two_pushed", pushed.size() - p0, 2)
    reset = 1'b1;
    @(negedge clk);
    `CHK("rst_mid_outputs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata, sh_mode,
         sh_new_rx_length, sh_set_rx_length, sh_wr_req, sh_data_in, sh_rd_req, crc_out}, 70'd0)
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    `CHK("rst_mid_no_done", done_cnt - d0, 0)
    run_tx(16'h0300, 5, "tx_after_reset");

    mem_max = 0; rx_gap = 0;
    q0 = rx_wr;
    for (int i = 0; i < 512; i++) rx_src[q0 + i] = 8'hFF;
    run_rx(16'h1000, 512, "rx_512_ff");
    `CHK("crc_512_ff", crc_out, crc_expect(16'h7FA1))

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
